pe_ws_dbuf: RTL and testbench

Parametrised weight-stationary processing element for the systolic array; next generation of the basic 8-bit PE.
- Adds a double-buffered weight (shadow plus active), so the next tile's weights shift in while the current tile computes.
- Adds a wide accumulator path with a signed/unsigned mode, optional saturation, and a sticky overflow flag.
- Carries valid qualifiers on the activation and partial-sum flows.
- Tiled into an R x C grid: activations flow east, partial sums flow south, weights shift south through the shadow chain.

---
 rtl/pe_ws_dbuf.sv | 118 +++++++++++
 tb/tb_pe_ws_dbuf.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_ws_dbuf.sv
// Weight-stationary systolic PE with double-buffered weight,
// wide signed/unsigned accumulate, optional saturation and sticky overflow.
module pe_ws_dbuf #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 20,
   parameter int SAT    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              signed_mode,
   input  logic [DATA_W-1:0] w_in,
   input  logic              w_shift_in,
   input  logic              w_swap_in,
   output logic [DATA_W-1:0] w_out,
   output logic              w_shift_out,
   output logic              w_swap_out,
   input  logic [DATA_W-1:0] a_in,
   input  logic              a_valid_in,
   output logic [DATA_W-1:0] a_out,
   output logic              a_valid_out,
   input  logic [ACC_W-1:0]  psum_in,
   input  logic              psum_valid_in,
   output logic [ACC_W-1:0]  psum_out,
   output logic              psum_valid_out,
   output logic              ovf
);

   generate
      if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
         $error("pe_ws_dbuf: ACC_W must be >= 2*DATA_W");
      end
   endgenerate

   localparam logic SAT_EN = (SAT != 0);
   localparam logic [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] S_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [ACC_W-1:0] U_MAX = {ACC_W{1'b1}};

   logic [DATA_W-1:0] shadow_q;
   logic [DATA_W-1:0] active_q;
   logic [ACC_W-1:0]  a_ext;
   logic [ACC_W-1:0]  w_ext;
   logic [ACC_W-1:0]  mul;
   logic [ACC_W-1:0]  prod;
   logic [ACC_W:0]    sum;
   logic              ovf_now;
   logic              sat_hit;
   logic [ACC_W-1:0]  res;

   assign w_out = shadow_q;

   // Operands extended to ACC_W so the truncated product is already
   // the sign/zero-extended 2*DATA_W result.
   always_comb begin
      a_ext = {{(ACC_W-DATA_W){signed_mode & a_in[DATA_W-1]}}, a_in};
      w_ext = {{(ACC_W-DATA_W){signed_mode & active_q[DATA_W-1]}},
               active_q};
      mul   = a_ext * w_ext;
      prod  = a_valid_in ? mul : '0;
      sum   = {1'b0, psum_in} + {1'b0, prod};
      if (signed_mode) begin
         ovf_now = (psum_in[ACC_W-1] == prod[ACC_W-1]) &&
                   (sum[ACC_W-1] != psum_in[ACC_W-1]);
      end else begin
         ovf_now = sum[ACC_W];
      end
      sat_hit = ovf_now & SAT_EN;
   end

   always_comb begin
      res = sum[ACC_W-1:0];
      unique case (1'b1)
         !sat_hit:
            res = sum[ACC_W-1:0];
         sat_hit && !signed_mode:
            res = U_MAX;
         sat_hit && signed_mode && psum_in[ACC_W-1]:
            res = S_MIN;
         sat_hit && signed_mode && !psum_in[ACC_W-1]:
            res = S_MAX;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q       <= '0;
         active_q       <= '0;
         w_shift_out    <= 1'b0;
         w_swap_out     <= 1'b0;
         a_out          <= '0;
         a_valid_out    <= 1'b0;
         psum_out       <= '0;
         psum_valid_out <= 1'b0;
         ovf            <= 1'b0;
      end else begin
         if (w_shift_in) shadow_q <= w_in;
         if (w_swap_in)  active_q <= shadow_q;
         w_shift_out <= w_shift_in;
         w_swap_out  <= w_swap_in;
         // Clear drops in-flight datapath state but keeps the weights.
         if (clear) begin
            a_out          <= '0;
            a_valid_out    <= 1'b0;
            psum_out       <= '0;
            psum_valid_out <= 1'b0;
            ovf            <= 1'b0;
         end else begin
            a_out          <= a_in;
            a_valid_out    <= a_valid_in;
            psum_out       <= res;
            psum_valid_out <= psum_valid_in;
            if (ovf_now) ovf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pe_ws_dbuf.sv
// Scoreboard bench for pe_ws_dbuf: SAT=1 and SAT=0 builds driven
// in lockstep, expectations from an integer reference model.
module tb_pe_ws_dbuf;

   logic        clk = 1'b0;
   logic        rst, clear, signed_mode;
   logic [7:0]  w_in, a_in;
   logic        w_shift_in, w_swap_in, a_valid_in, psum_valid_in;
   logic [19:0] psum_in;

   logic [7:0]  w_out, a_out, w_out_w, a_out_w;
   logic        w_shift_out, w_swap_out, a_valid_out, psum_valid_out, ovf;
   logic        w_shift_out_w, w_swap_out_w, a_valid_out_w;
   logic        psum_valid_out_w, ovf_w;
   logic [19:0] psum_out, psum_out_w;

   always #5 clk = ~clk;

   pe_ws_dbuf #(.DATA_W(8), .ACC_W(20), .SAT(1)) u_sat (
      .clk(clk), .rst(rst), .clear(clear), .signed_mode(signed_mode),
      .w_in(w_in), .w_shift_in(w_shift_in), .w_swap_in(w_swap_in),
      .w_out(w_out), .w_shift_out(w_shift_out), .w_swap_out(w_swap_out),
      .a_in(a_in), .a_valid_in(a_valid_in),
      .a_out(a_out), .a_valid_out(a_valid_out),
      .psum_in(psum_in), .psum_valid_in(psum_valid_in),
      .psum_out(psum_out), .psum_valid_out(psum_valid_out), .ovf(ovf)
   );

   pe_ws_dbuf #(.DATA_W(8), .ACC_W(20), .SAT(0)) u_wrap (
      .clk(clk), .rst(rst), .clear(clear), .signed_mode(signed_mode),
      .w_in(w_in), .w_shift_in(w_shift_in), .w_swap_in(w_swap_in),
      .w_out(w_out_w), .w_shift_out(w_shift_out_w),
      .w_swap_out(w_swap_out_w),
      .a_in(a_in), .a_valid_in(a_valid_in),
      .a_out(a_out_w), .a_valid_out(a_valid_out_w),
      .psum_in(psum_in), .psum_valid_in(psum_valid_in),
      .psum_out(psum_out_w), .psum_valid_out(psum_valid_out_w),
      .ovf(ovf_w)
   );

   typedef struct {
      logic        clr;
      logic        sm;
      logic [7:0]  w;
      logic        sh;
      logic        sw;
      logic [7:0]  a;
      logic        av;
      logic [19:0] p;
      logic        pv;
   } vec_t;

   typedef struct {
      logic [19:0] ps;
      logic [19:0] pw;
      logic [7:0]  a;
      logic        av;
      logic        pv;
      logic        o;
      logic [7:0]  wo;
      logic        wsh;
      logic        wsw;
   } exp_t;

   exp_t       sb[$];
   int         n_pass = 0;
   int         n_tot  = 0;
   logic [7:0] m_shadow, m_active;
   logic       m_ovf;

   function automatic vec_t mv(logic clr, logic sm, logic [7:0] w,
                               logic sh, logic sw, logic [7:0] a,
                               logic av, logic [19:0] p, logic pv);
      vec_t v;
      v.clr = clr; v.sm = sm; v.w = w; v.sh = sh; v.sw = sw;
      v.a = a; v.av = av; v.p = p; v.pv = pv;
      return v;
   endfunction

   // Exact integer arithmetic, then range-checked against the ACC_W window.
   function automatic void ref_mac(input logic sm, input logic av,
                                   input logic [7:0] a, input logic [7:0] w,
                                   input logic [19:0] p,
                                   output logic [19:0] rs,
                                   output logic [19:0] rw,
                                   output logic o);
      longint pa, pb, pp, s, lo, hi;
      if (sm) begin
         pa = longint'($signed(a));
         pb = longint'($signed(w));
         pp = longint'($signed(p));
         lo = -(longint'(1) <<< 19);
         hi = (longint'(1) <<< 19) - 1;
      end else begin
         pa = longint'(a);
         pb = longint'(w);
         pp = longint'(p);
         lo = 0;
         hi = (longint'(1) <<< 20) - 1;
      end
      if (!av) pa = 0;
      s  = pp + pa * pb;
      o  = (s > hi) || (s < lo);
      rw = s[19:0];
      if (s > hi)      rs = hi[19:0];
      else if (s < lo) rs = lo[19:0];
      else             rs = s[19:0];
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_shadow = '0;
      m_active = '0;
      m_ovf    = 1'b0;
   endtask

   task automatic apply(input vec_t v);
      exp_t        e;
      logic [19:0] rs, rw;
      logic        o;
      clear = v.clr; signed_mode = v.sm; w_in = v.w;
      w_shift_in = v.sh; w_swap_in = v.sw; a_in = v.a;
      a_valid_in = v.av; psum_in = v.p; psum_valid_in = v.pv;
      ref_mac(v.sm, v.av, v.a, m_active, v.p, rs, rw, o);
      if (v.clr) begin
         e.ps = '0; e.pw = '0; e.a = '0; e.av = 1'b0; e.pv = 1'b0;
         m_ovf = 1'b0;
      end else begin
         e.ps = rs; e.pw = rw; e.a = v.a; e.av = v.av; e.pv = v.pv;
         m_ovf = m_ovf | o;
      end
      e.o = m_ovf;
      if (v.sw) m_active = m_shadow;
      if (v.sh) m_shadow = v.w;
      e.wo  = m_shadow;
      e.wsh = v.sh;
      e.wsw = v.sw;
      sb.push_back(e);
   endtask

   task automatic idle();
      clear = 0; signed_mode = 0; w_in = 0; w_shift_in = 0;
      w_swap_in = 0; a_in = 0; a_valid_in = 0; psum_in = 0;
      psum_valid_in = 0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      cyc();
      clear = 1; w_in = 8'h5A; w_shift_in = 1; w_swap_in = 1;
      a_in = 8'h11; a_valid_in = 1; psum_in = 20'h12345;
      psum_valid_in = 1; signed_mode = 1;
      cyc();
      n_tot++;
      if ({psum_out, psum_out_w, a_out, a_out_w} !== '0)
         $display("FAIL reset_data got %h %h %h %h exp 0",
                  psum_out, psum_out_w, a_out, a_out_w);
      else n_pass++;
      n_tot++;
      if ({a_valid_out, psum_valid_out, ovf, ovf_w, w_out, w_shift_out,
           w_swap_out, a_valid_out_w, psum_valid_out_w, w_out_w,
           w_shift_out_w, w_swap_out_w} !== '0)
         $display("FAIL reset_ctrl got av=%b pv=%b ovf=%b wo=%h exp 0",
                  a_valid_out, psum_valid_out, ovf, w_out);
      else n_pass++;
      rst = 1'b0;
      idle();
      model_reset();
   endtask

   task automatic run_vecs(input string tag, input vec_t t[$]);
      exp_t e;
      foreach (t[i]) begin
         apply(t[i]);
         cyc();
         e = sb.pop_front();
         n_tot++;
         if ({psum_out, psum_out_w} !== {e.ps, e.pw})
            $display("FAIL %s[%0d] psum sat/wrap got %h/%h exp %h/%h",
                     tag, i, psum_out, psum_out_w, e.ps, e.pw);
         else n_pass++;
         n_tot++;
         if ({a_out, a_valid_out, psum_valid_out,
              a_out_w, a_valid_out_w, psum_valid_out_w}
             !== {e.a, e.av, e.pv, e.a, e.av, e.pv})
            $display("FAIL %s[%0d] a/valid got %h %b %b exp %h %b %b",
                     tag, i, a_out, a_valid_out, psum_valid_out,
                     e.a, e.av, e.pv);
         else n_pass++;
         n_tot++;
         if ({ovf, ovf_w} !== {e.o, e.o})
            $display("FAIL %s[%0d] ovf got %b/%b exp %b",
                     tag, i, ovf, ovf_w, e.o);
         else n_pass++;
         n_tot++;
         if ({w_out, w_shift_out, w_swap_out,
              w_out_w, w_shift_out_w, w_swap_out_w}
             !== {e.wo, e.wsh, e.wsw, e.wo, e.wsh, e.wsw})
            $display("FAIL %s[%0d] wchain got %h %b %b exp %h %b %b",
                     tag, i, w_out, w_shift_out, w_swap_out,
                     e.wo, e.wsh, e.wsw);
         else n_pass++;
      end
   endtask

   task automatic test_basic();
      vec_t t[$];
      t.push_back(mv(0, 1, 8'd3, 1, 0, 8'd0, 0, 20'd0, 0));
      t.push_back(mv(0, 1, 8'd0, 0, 1, 8'd0, 0, 20'd0, 0));
      t.push_back(mv(0, 1, 8'd0, 0, 0, 8'd5, 1, 20'd10, 1));
      run_vecs("basic", t);
      n_tot++;
      if ({psum_out, a_out, a_valid_out} !== {20'd25, 8'd5, 1'b1})
         $display("FAIL basic_mac got %0d %0d %b exp 25 5 1",
                  psum_out, a_out, a_valid_out);
      else n_pass++;
   endtask

   task automatic test_signed_unsigned();
      vec_t t[$];
      t.push_back(mv(0, 1, 8'hFE, 1, 0, 8'd0, 0, 20'd0, 0));
      t.push_back(mv(0, 1, 8'd0, 0, 1, 8'd0, 0, 20'd0, 0));
      t.push_back(mv(0, 1, 8'd0, 0, 0, 8'd7, 1, 20'd0, 1));
      run_vecs("signed", t);
      n_tot++;
      if (psum_out !== 20'hFFFF2)
         $display("FAIL signed_mul got %h exp FFFF2", psum_out);
      else n_pass++;
      t.delete();
      t.push_back(mv(0, 0, 8'd0, 0, 0, 8'd7, 1, 20'd0, 1));
      run_vecs("unsigned", t);
      n_tot++;
      if (psum_out !== 20'h006F2)
         $display("FAIL unsigned_mul got %h exp 006F2", psum_out);
      else n_pass++;
   endtask

   task automatic test_saturation();
      vec_t t[$];
      t.push_back(mv(1, 1, 8'd1, 1, 0, 8'd0, 0, 20'd0, 0));
      t.push_back(mv(0, 1, 8'd0, 0, 1, 8'd0, 0, 20'd0, 0));
      t.push_back(mv(0, 1, 8'd0, 0, 0, 8'd1, 1, 20'h7FFFF, 1));
      run_vecs("sat_pos", t);
      n_tot++;
      if ({psum_out, psum_out_w, ovf, ovf_w}
          !== {20'h7FFFF, 20'h80000, 1'b1, 1'b1})
         $display("FAIL sat_pos got %h/%h ovf %b/%b exp 7FFFF/80000 1/1",
                  psum_out, psum_out_w, ovf, ovf_w);
      else n_pass++;
      t.delete();
      t.push_back(mv(0, 1, 8'd0, 0, 0, 8'd1, 1, 20'd0, 1));
      t.push_back(mv(0, 1, 8'd0, 0, 0, 8'hFF, 1, 20'h80000, 1));
      t.push_back(mv(0, 0, 8'd0, 0, 0, 8'hFF, 1, 20'hFFFFF, 1));
      t.push_back(mv(0, 0, 8'd0, 0, 0, 8'h01, 1, 20'h00010, 1));
      run_vecs("sat_more", t);
      n_tot++;
      if ({psum_out, ovf} !== {20'h00011, 1'b1})
         $display("FAIL ovf_sticky got %h ovf %b exp 00011 1",
                  psum_out, ovf);
      else n_pass++;
   endtask

   task automatic test_double_buffer();
      vec_t t[$];
      t.push_back(mv(1, 0, 8'd3, 1, 0, 8'd0, 0, 20'd0, 0));
      t.push_back(mv(0, 0, 8'd0, 0, 1, 8'd0, 0, 20'd0, 0));
      t.push_back(mv(0, 0, 8'd9, 1, 0, 8'd2, 1, 20'd0, 1));
      t.push_back(mv(0, 0, 8'd0, 0, 0, 8'd2, 1, 20'd0, 1));
      t.push_back(mv(0, 0, 8'd0, 0, 1, 8'd2, 1, 20'd0, 1));
      t.push_back(mv(0, 0, 8'd0, 0, 0, 8'd2, 1, 20'd0, 1));
      t.push_back(mv(0, 0, 8'd6, 1, 0, 8'd2, 1, 20'd0, 1));
      t.push_back(mv(0, 0, 8'd4, 1, 1, 8'd2, 1, 20'd0, 1));
      t.push_back(mv(0, 0, 8'd0, 0, 0, 8'd1, 1, 20'd0, 1));
      run_vecs("dbuf", t);
      n_tot++;
      if ({psum_out, w_out} !== {20'd6, 8'd4})
         $display("FAIL dbuf_swap_shift got %0d w_out %0d exp 6 4",
                  psum_out, w_out);
      else n_pass++;
   endtask

   task automatic test_pass_through();
      vec_t t[$];
      t.push_back(mv(0, 1, 8'd0, 0, 0, 8'hFF, 0, 20'd100, 1));
      t.push_back(mv(0, 0, 8'd0, 0, 0, 8'hFF, 0, 20'hFFFFF, 0));
      run_vecs("pass", t);
      n_tot++;
      if ({psum_out, a_valid_out, ovf} !== {20'hFFFFF, 1'b0, 1'b0})
         $display("FAIL pass_thru got %h av %b ovf %b exp FFFFF 0 0",
                  psum_out, a_valid_out, ovf);
      else n_pass++;
   endtask

   task automatic test_clear_reset();
      vec_t t[$];
      t.push_back(mv(0, 1, 8'd3, 1, 0, 8'd0, 0, 20'd0, 0));
      t.push_back(mv(0, 1, 8'd0, 0, 1, 8'd0, 0, 20'd0, 0));
      t.push_back(mv(0, 1, 8'd0, 0, 0, 8'd1, 1, 20'h7FFFF, 1));
      t.push_back(mv(1, 1, 8'd0, 0, 0, 8'd5, 1, 20'h7FFFF, 1));
      run_vecs("clear", t);
      n_tot++;
      if ({psum_out, a_out, ovf} !== {20'd0, 8'd0, 1'b0})
         $display("FAIL clear_out got %h %h ovf %b exp 0 0 0",
                  psum_out, a_out, ovf);
      else n_pass++;
      t.delete();
      t.push_back(mv(0, 1, 8'd0, 0, 0, 8'd1, 1, 20'd0, 1));
      run_vecs("clear_keep", t);
      n_tot++;
      if (psum_out !== 20'd3)
         $display("FAIL clear_keeps_weight got %0d exp 3", psum_out);
      else n_pass++;
      test_reset();
      t.delete();
      t.push_back(mv(0, 1, 8'd0, 0, 0, 8'd1, 1, 20'd0, 1));
      run_vecs("rst_wt", t);
      n_tot++;
      if ({psum_out, a_out} !== {20'd0, 8'd1})
         $display("FAIL rst_kills_weight got %0d a %0d exp 0 1",
                  psum_out, a_out);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      vec_t t[$];
      logic [19:0] p;
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 3))
            0: p = 20'h7FF00 | 20'($urandom_range(0, 255));
            1: p = 20'hFFF00 | 20'($urandom_range(0, 255));
            2: p = 20'h80000 | 20'($urandom_range(0, 255));
            default: p = 20'($urandom);
         endcase
         t.push_back(mv($urandom_range(0, 15) == 0,
                        1'($urandom), 8'($urandom),
                        1'($urandom), $urandom_range(0, 3) == 0,
                        8'($urandom), $urandom_range(0, 3) != 0,
                        p, 1'($urandom)));
      end
      run_vecs("b2b", t);
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_signed_unsigned();
      test_saturation();
      test_double_buffer();
      test_pass_through();
      test_clear_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
